chip_loader: RTL and testbench
==============================

# chip_loader

Host-side sequencer for the CNN accelerator's byte-serial load port. On `start` it resets the accelerator, streams one 8x8x1 image (64 bytes, mode 0) from a byte memory, then the 3x3x3x2 weight set (54 bytes, mode 1), and waits for `out_data_flag`. It then captures the 8-bit signed result and pulses `done`. It is the driving end of the `rst_n`/`mode`/`din`/`ram_en` → `dout`/`out_data_flag` interface, and sits between a sample/weight memory and the accelerator top.

## Interface
Parameters:
- `ADDR_W`, 16: memory address width.
- `IMG_W`, 7: image index width.
- `DATA_BASE`, 0: byte address of image 0.
- `WEIGHT_BASE`, 6400: byte address of weight byte 0.
- `CHIP_RST_CYC`, 4: cycles the accelerator reset is held low; must be ≥1.
- `TIMEOUT_CYC`, 1024: WAIT watchdog limit. Only used with `LOADER_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin one image; sampled only in IDLE.
- `img_idx` in IMG_W: image number; latched on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out 8: captured accelerator output (two's complement).
- `timeout` out 1: sticky watchdog flag.
- `mem_en` out 1: memory read enable.
- `mem_addr` out ADDR_W: memory read address.
- `mem_rdata` in 8: read data, valid 1 cycle after `mem_en`.
- `chip_rst_n` out 1: accelerator reset.
- `chip_mode` out 1: 0 = image byte, 1 = weight byte.
- `chip_din` out 8: load byte.
- `chip_ram_en` out 1: load strobe.
- `chip_dout` in 8: accelerator result.
- `chip_out_flag` in 1: accelerator result valid.

## Operation
- States: IDLE → CRST → LOAD → DRAIN → WAIT → DONE → IDLE.
- IDLE: `start`=1 latches `img_idx`, clears `timeout`, and moves to CRST.
- CRST: lasts CHIP_RST_CYC cycles with `chip_rst_n`=0, then moves to LOAD.
- LOAD: lasts 118 cycles. The byte counter n runs 0..117 and one read is issued per cycle.
  - n<64: `mem_addr` = DATA_BASE + img_idx*64 + n.
  - n≥64: `mem_addr` = WEIGHT_BASE + (n−64).
  - Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W.
- Output pipeline: `mem_rdata` is registered into `chip_din`. `chip_ram_en` and `chip_mode` (= n≥64) are carried through a 2-stage tag pipeline so they are aligned with `chip_din`.
- DRAIN: 2 cycles that flush the pipeline, then move to WAIT.
- WAIT: `chip_out_flag`=1 → `result` ← `chip_dout`, move to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `chip_out_flag` is ignored outside WAIT. `start` is ignored while `busy`.
- `rst_n`=0 in any state: all registers return to reset values next edge. There is no partial resume, and the accelerator sees `chip_rst_n`=0 during the reset.
- Reset values:
  - `busy`, `done`, `timeout`, `mem_en`, `chip_mode`, `chip_ram_en`, `chip_rst_n` = 0.
  - `result`, `chip_din`, `mem_addr` = 0.
  - `chip_rst_n` goes 1 on the first edge after release (IDLE drives 1).

## Timing
- Cycle 0 = edge sampling `start`=1 in IDLE.
- `chip_rst_n`=0 in cycles 1..CHIP_RST_CYC.
- LOAD: cycles CHIP_RST_CYC+1 .. CHIP_RST_CYC+118; `mem_en`=1 only there.
- `chip_ram_en`=1 for exactly 118 consecutive cycles, starting 2 cycles after the first LOAD cycle.
  - `chip_mode`=0 for the first 64 of them and 1 for the last 54.
  - There are no gaps.
- WAIT starts at cycle CHIP_RST_CYC+121.
- `chip_out_flag` seen in cycle t → `done`=1 and new `result` in cycle t+1.
- `start` asserted in the DONE cycle is ignored; it is accepted from the following IDLE cycle.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A WAIT counter runs. After TIMEOUT_CYC cycles in WAIT without the flag, `timeout` is set, `result` ← 8'h80, and the FSM goes to DONE (`done` pulses).
  - `timeout` stays set until the next accepted `start` or reset.
  - A flag arriving in the same cycle the limit is reached wins: normal capture, `timeout` stays 0.
- `LOADER_TIMEOUT_EN` undefined: no counter, `timeout` is tied 0, and WAIT is unbounded.

## Structure
- `chip_loader_pkg` holds:
  - the state enum;
  - DATA_BYTES=64, WEIGHT_BYTES=54, TOTAL_BYTES=118;
  - the timeout result constant 8'h80.
- One sub-module, `chip_loader_addr_gen`, holds the byte counter, the base/offset address computation and the mode tag. The FSM and output pipeline stay in `chip_loader`.

## Test plan
- Reset, then start with img_idx=3, CHIP_RST_CYC=4:
  - `chip_rst_n` is low in cycles 1–4.
  - `mem_addr` runs 192..255, then 6400..6453.
  - `chip_ram_en` is high in cycles 7–124, with `chip_mode` switching to 1 at cycle 71.
- Memory model returning addr[7:0]: `chip_din` sequence equals the expected 118 address bytes, each aligned with `chip_ram_en`.
- Flag raised in cycle 200 with `chip_dout`=8'hF6 → `done` in cycle 201 with `result`=−10; `busy`=0 in cycle 202.
- `start` pulsed while in LOAD, and `chip_out_flag` pulsed during CRST → both ignored; the sequence and `result` are unchanged.
- `rst_n` low for 1 cycle mid-LOAD → all outputs take reset values; a fresh start then reproduces the full sequence from n=0.
- With `LOADER_TIMEOUT_EN`, TIMEOUT_CYC=16, no flag:
  - `done` fires 16 cycles into WAIT with `result`=8'h80 and `timeout`=1.
  - The next start clears `timeout`.

Source files
------------

// File: rtl/chip_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chip_loader_pkg
//  Description : Shared types and constants for the CNN accelerator load-port
//                sequencer: FSM state encoding, load-stream byte counts and
//                the result value reported on a WAIT watchdog expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
package chip_loader_pkg;

    // Sequencer states, explicitly encoded on 3 bits.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // One 8x8x1 image followed by the 3x3x3x2 weight set.
    localparam int DATA_BYTES   = 64;
    localparam int WEIGHT_BYTES = 54;
    localparam int TOTAL_BYTES  = DATA_BYTES + WEIGHT_BYTES;

    // Byte counter width, enough to hold 0..TOTAL_BYTES-1.
    localparam int BYTE_CNT_W = 7;

    // Value placed on result when the WAIT watchdog gives up.
    localparam logic [7:0] TIMEOUT_RESULT = 8'h80;

    // True once the stream has moved past the image bytes into the weights.
    function automatic logic is_weight_byte(input logic [BYTE_CNT_W-1:0] n);
        return (n >= BYTE_CNT_W'(DATA_BYTES));
    endfunction

endpackage : chip_loader_pkg
`default_nettype wire

// File: rtl/chip_loader_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : chip_loader_addr_gen
//  Description : Byte counter and read-address generator for the load stream.
//                While i_advance is high the counter walks 0..TOTAL_BYTES-1;
//                the first DATA_BYTES reads target the selected image, the
//                rest target the weight table. Address math wraps at ADDR_W.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                i_advance         - high in every LOAD cycle
//                i_img_idx         - latched image number
//                o_addr            - memory read address for the current byte
//                o_mode            - 0 = image byte, 1 = weight byte
//                o_last            - current byte is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module chip_loader_addr_gen #(
    parameter int ADDR_W      = 16,
    parameter int IMG_W       = 7,
    parameter int DATA_BASE   = 0,
    parameter int WEIGHT_BASE = 6400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_advance,
    input  logic [IMG_W-1:0]  i_img_idx,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_mode,
    output logic              o_last
);
    import chip_loader_pkg::*;

    // Each image occupies DATA_BYTES consecutive bytes.
    localparam int c_IMG_SHIFT = $clog2(DATA_BYTES);

    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [BYTE_CNT_W-1:0] w_wgt_off;
    logic [ADDR_W-1:0]     w_img_base;

    // The counter idles at zero so the next LOAD always starts from byte 0,
    // including after a reset that interrupted a previous stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_advance) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_comb begin
        o_mode     = is_weight_byte(r_cnt);
        o_last     = (r_cnt == BYTE_CNT_W'(TOTAL_BYTES - 1));
        w_wgt_off  = r_cnt - BYTE_CNT_W'(DATA_BYTES);
        w_img_base = ADDR_W'(DATA_BASE) + (ADDR_W'(i_img_idx) << c_IMG_SHIFT);
        if (o_mode) begin
            o_addr = ADDR_W'(WEIGHT_BASE) + ADDR_W'(w_wgt_off);
        end else begin
            o_addr = w_img_base + ADDR_W'(r_cnt);
        end
    end

endmodule : chip_loader_addr_gen
`default_nettype wire

// File: rtl/chip_loader.sv
`default_nettype none
// ============================================================================
//  Module      : chip_loader
//  Description : Host-side sequencer for the CNN accelerator byte-serial load
//                port. On start: hold the accelerator in reset, stream one
//                image then the weight set from byte memory, wait for the
//                result flag, capture the signed result and pulse done.
//  Config      : `define LOADER_TIMEOUT_EN to enable the WAIT watchdog
//                (TIMEOUT_CYC cycles, result forced to 8'h80, sticky timeout).
//  Ports       : clk, rst_n                 - clock, sync active-low reset
//                start, img_idx             - request and image number
//                busy, done, result, timeout- status / result
//                mem_en, mem_addr, mem_rdata- byte memory read port
//                chip_rst_n, chip_mode,
//                chip_din, chip_ram_en      - accelerator load port
//                chip_dout, chip_out_flag   - accelerator result port
//  Revision    : 1.0 - initial release
// ============================================================================
module chip_loader #(
    parameter int ADDR_W       = 16,
    parameter int IMG_W        = 7,
    parameter int DATA_BASE    = 0,
    parameter int WEIGHT_BASE  = 6400,
    parameter int CHIP_RST_CYC = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IMG_W-1:0]  img_idx,
    output logic              busy,
    output logic              done,
    output logic [7:0]        result,
    output logic              timeout,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              chip_rst_n,
    output logic              chip_mode,
    output logic [7:0]        chip_din,
    output logic              chip_ram_en,
    input  logic [7:0]        chip_dout,
    input  logic              chip_out_flag
);
    import chip_loader_pkg::*;

    generate
        if (CHIP_RST_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
            $error("chip_loader: CHIP_RST_CYC and TIMEOUT_CYC must be >= 1");
        end
    endgenerate

    localparam int c_CRST_W = (CHIP_RST_CYC > 1) ? $clog2(CHIP_RST_CYC) : 1;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CRST_W-1:0] r_crst_cnt;
    logic                r_drain;
    logic [IMG_W-1:0]    r_img_idx;
    logic [7:0]          r_result;
    logic [7:0]          r_din;
    logic                r_chip_rst_n;
    logic [1:0]          r_tag_en;
    logic [1:0]          r_tag_mode;

    logic                w_load;
    logic                w_last;
    logic                w_byte_mode;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_accept;
    logic                w_capture;
    logic                w_expire;

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    chip_loader_addr_gen #(
        .ADDR_W      (ADDR_W),
        .IMG_W       (IMG_W),
        .DATA_BASE   (DATA_BASE),
        .WEIGHT_BASE (WEIGHT_BASE)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_advance (w_load),
        .i_img_idx (r_img_idx),
        .o_addr    (w_addr),
        .o_mode    (w_byte_mode),
        .o_last    (w_last)
    );

    // ------------------------------------------------------------------
    // WAIT watchdog
    // ------------------------------------------------------------------
`ifdef LOADER_TIMEOUT_EN
    localparam int c_WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout;

    // A flag in the final allowed cycle takes priority over the expiry.
    assign w_expire = (r_state == S_WAIT) && !chip_out_flag &&
                      (r_wait_cnt == c_WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_CRST;
                end
            end
            S_CRST: begin
                if (r_crst_cnt == c_CRST_W'(CHIP_RST_CYC - 1)) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Two cycles let the last byte leave the output pipeline.
                if (r_drain) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (chip_out_flag) begin
                    w_capture    = 1'b1;
                    w_next_state = S_DONE;
                end else if (w_expire) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register, counters and output pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_crst_cnt   <= '0;
            r_drain      <= 1'b0;
            r_img_idx    <= '0;
            r_result     <= 8'h00;
            r_din        <= 8'h00;
            r_chip_rst_n <= 1'b0;
            r_tag_en     <= 2'b00;
            r_tag_mode   <= 2'b00;
        end else begin
            r_state    <= w_next_state;
            r_crst_cnt <= (r_state == S_CRST) ? r_crst_cnt + 1'b1 : '0;
            r_drain    <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;

            if (w_accept) begin
                r_img_idx <= img_idx;
            end

            if (w_capture) begin
                r_result <= chip_dout;
            end else if (w_expire) begin
                r_result <= TIMEOUT_RESULT;
            end

            // Registered from the next state so the accelerator reset is
            // low in exactly the CRST cycles.
            r_chip_rst_n <= (w_next_state != S_CRST);

            // Stage 0 lines up with mem_rdata, stage 1 with chip_din.
            r_tag_en   <= {r_tag_en[0], w_load};
            r_tag_mode <= {r_tag_mode[0], w_load & w_byte_mode};
            if (r_tag_en[0]) begin
                r_din <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_load      = (r_state == S_LOAD);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign result      = r_result;
    assign mem_en      = w_load;
    assign mem_addr    = w_load ? w_addr : '0;
    assign chip_rst_n  = r_chip_rst_n;
    assign chip_mode   = r_tag_mode[1];
    assign chip_ram_en = r_tag_en[1];
    assign chip_din    = r_din;

endmodule : chip_loader
`default_nettype wire

// File: tb/tb_chip_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip_loader
//  Description : Self-checking bench for chip_loader. A table of directed
//                transactions plus randomized ones are run; every cycle of
//                each transaction is compared against expectations derived
//                from the cycle-level timing rules and a byte memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_loader;

    localparam int ADDR_W      = 16;
    localparam int IMG_W       = 7;
    localparam int DATA_BASE   = 0;
    localparam int WEIGHT_BASE = 6400;
    localparam int CRST        = 4;
    localparam int TCYC        = 16;
`ifdef LOADER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk           = 1'b0;
    logic              rst_n         = 1'b0;
    logic              start         = 1'b0;
    logic [IMG_W-1:0]  img_idx       = '0;
    logic [7:0]        chip_dout     = 8'h00;
    logic              chip_out_flag = 1'b0;
    logic [7:0]        mem_rdata     = 8'h00;
    logic              busy, done, timeout, mem_en, chip_rst_n, chip_mode, chip_ram_en;
    logic [7:0]        result, chip_din;
    logic [ADDR_W-1:0] mem_addr;

    logic [7:0] mem [0:65535];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev_result = 8'h00;
    bit         prev_to     = 1'b0;

    typedef struct {
        int         idx;
        int         fdelay;   // flag cycle, counted from the first WAIT cycle
        logic [7:0] dout;
        int         exp_val;  // expected signed result when no timeout
        bit         g_start;  // extra start pulse during LOAD
        bit         g_flag;   // stray flag pulse during CRST
    } vec_t;

    vec_t tbl [5];

    chip_loader #(
        .ADDR_W       (ADDR_W),
        .IMG_W        (IMG_W),
        .DATA_BASE    (DATA_BASE),
        .WEIGHT_BASE  (WEIGHT_BASE),
        .CHIP_RST_CYC (CRST),
        .TIMEOUT_CYC  (TCYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .img_idx       (img_idx),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .timeout       (timeout),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .chip_rst_n    (chip_rst_n),
        .chip_mode     (chip_mode),
        .chip_din      (chip_din),
        .chip_ram_en   (chip_ram_en),
        .chip_dout     (chip_dout),
        .chip_out_flag (chip_out_flag)
    );

    always #5 clk = ~clk;

    // Byte memory: one-cycle read latency.
    always @(posedge clk) mem_rdata <= mem_en ? mem[mem_addr] : 8'h00;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    // Byte n of the load stream lives at this memory address.
    function automatic int exp_addr(input int idx, input int n);
        if (n < 64) return (DATA_BASE + idx * 64 + n) % 65536;
        return (WEIGHT_BASE + n - 64) % 65536;
    endfunction

    // One complete transaction. Cycle 0 is the cycle whose edge samples start.
    task automatic run_seq(input int idx, input int fdelay, input logic [7:0] dout,
                           input logic [7:0] exp_norm, input bit g_start, input bit g_flag);
        int         wait0;
        int         done_t;
        int         n;
        bit         to;
        logic [7:0] exp_res;
        wait0   = CRST + 121;
        to      = TO_EN && (fdelay >= TCYC);
        done_t  = to ? wait0 + TCYC : wait0 + fdelay + 1;
        exp_res = to ? 8'h80 : exp_norm;
        img_idx = idx[IMG_W-1:0];
        for (int t = 0; t <= done_t + 1; t++) begin
            @(negedge clk);
            chk("busy",        t, busy,        (t >= 1 && t <= done_t));
            chk("done",        t, done,        (t == done_t));
            chk("chip_rst_n",  t, chip_rst_n,  !(t >= 1 && t <= CRST));
            chk("mem_en",      t, mem_en,      (t >= CRST + 1 && t <= CRST + 118));
            if (t >= CRST + 1 && t <= CRST + 118)
                chk("mem_addr", t, mem_addr, exp_addr(idx, t - CRST - 1));
            chk("chip_ram_en", t, chip_ram_en, (t >= CRST + 3 && t <= CRST + 120));
            if (t >= CRST + 3 && t <= CRST + 120) begin
                n = t - CRST - 3;
                chk("chip_din",  t, chip_din,  mem[exp_addr(idx, n)]);
                chk("chip_mode", t, chip_mode, (n >= 64));
            end
            chk("result",  t, result,  (t >= done_t) ? exp_res : prev_result);
            chk("timeout", t, timeout, (t == 0) ? prev_to : (t >= done_t && to));
            // Inputs for this cycle; start in the DONE cycle must be ignored.
            start         = (t == 0) || (g_start && t == CRST + 10) || (t == done_t);
            chip_out_flag = (!to && t == wait0 + fdelay) || (g_flag && t == 2);
            chip_dout     = (!to && t == wait0 + fdelay) ? dout : 8'($urandom);
        end
        start         = 1'b0;
        chip_out_flag = 1'b0;
        prev_result   = exp_res;
        prev_to       = to;
    endtask

    task automatic chk_reset_values(input int t);
        chk("rst busy",        t, busy,        0);
        chk("rst done",        t, done,        0);
        chk("rst timeout",     t, timeout,     0);
        chk("rst mem_en",      t, mem_en,      0);
        chk("rst chip_mode",   t, chip_mode,   0);
        chk("rst chip_ram_en", t, chip_ram_en, 0);
        chk("rst chip_rst_n",  t, chip_rst_n,  0);
        chk("rst result",      t, result,      0);
        chk("rst chip_din",    t, chip_din,    0);
        chk("rst mem_addr",    t, mem_addr,    0);
    endtask

    initial begin
        logic [7:0] rd;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a);

        tbl[0] = '{3,   75, 8'hF6,  -10,  1'b0, 1'b0};
        tbl[1] = '{3,   75, 8'hF6,  -10,  1'b1, 1'b1};
        tbl[2] = '{0,    0, 8'h7F,  127,  1'b0, 1'b1};
        tbl[3] = '{127, 15, 8'h80, -128,  1'b1, 1'b0};
        tbl[4] = '{64,  16, 8'h01,    1,  1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values(-1);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_seq(tbl[i].idx, tbl[i].fdelay, tbl[i].dout, 8'(tbl[i].exp_val),
                    tbl[i].g_start, tbl[i].g_flag);

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            run_seq(int'($urandom_range(0, 127)), int'($urandom_range(0, 30)), rd, rd,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset for one cycle in the middle of LOAD, then a fresh transaction.
        img_idx = 7'd9;
        for (int t = 0; t <= 40; t++) begin
            @(negedge clk);
            start = (t == 0);
        end
        chk("mid-load mem_en", 40, mem_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_values(41);
        rst_n       = 1'b1;
        prev_result = 8'h00;
        prev_to     = 1'b0;
        run_seq(9, 4, 8'h5A, 8'h5A, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_chip_loader
`default_nettype wire
